mmind_scorer: RTL and testbench
===============================

MMIND_SCORER -- requirements
Module: mmind_scorer

Interface
REQ-001 The block SHALL have parameter COLOR_W, default 3, giving the bit width of one peg colour; there are 2^COLOR_W colours.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 The block SHALL have port start, input, 1 bit: request to score the present secret/guess pair.
REQ-005 The block SHALL have port secret, input, 4*COLOR_W bits: hidden code {p3,p2,p1,p0}, p0 in the LSBs.
REQ-006 The block SHALL have port guess, input, 4*COLOR_W bits: player code, same packing as secret.
REQ-007 The block SHALL have port busy, output, 1 bit: high while scoring is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse when new results are valid.
REQ-009 The block SHALL have port black, output, 3 bits: count of colour-and-position matches (0..4).
REQ-010 The block SHALL have port white, output, 3 bits: count of colour-only matches (0..4).
REQ-011 The block SHALL have port win, output, 1 bit: high when black == 4.

Function
REQ-012 The FSM SHALL have states IDLE, BLACK, COLOR and FINISH; busy SHALL equal (state != IDLE), decoded from registered state.
REQ-013 In IDLE with start=1 at a clock edge, the block SHALL latch secret and guess, clear idx, black_acc and total, and enter BLACK; start in any other state SHALL be ignored.
REQ-014 Operand changes after the latching edge SHALL NOT affect the result in progress.
REQ-015 BLACK SHALL take exactly 4 cycles, covering positions 0..3 in order, one per cycle: black_acc increments when secret[idx] == guess[idx]; after idx 3 the FSM enters COLOR with colour counter c = 0.
REQ-016 COLOR SHALL take exactly 2^COLOR_W cycles, one colour per cycle: total += min(count of c in latched secret, count of c in latched guess); after the last colour the FSM enters FINISH.
REQ-017 FINISH SHALL last 1 cycle: it registers black <= black_acc, white <= total - black_acc and win <= (black_acc == 4), sets done = 1 for exactly one cycle, and returns to IDLE.
REQ-018 With the default COLOR_W = 3, done SHALL be high in the cycle following the 13th rising edge after the edge that sampled start, i.e. 14 cycles from start acceptance to done deassertion.
REQ-019 black, white and win SHALL hold their values from the last FINISH until the next FINISH or reset.
REQ-020 start=1 in the cycle where done=1 SHALL be accepted, because the FSM is in IDLE; a start held continuously high SHALL produce back-to-back scorings with period 14 cycles.
REQ-021 All arithmetic SHALL be unsigned, with 3-bit accumulators; total is always >= black_acc and <= 4, so white never underflows.

Reset
REQ-022 When reset = 0, the block SHALL immediately, without waiting for a clock edge, force state = IDLE, busy = 0, done = 0, black = 0, white = 0, win = 0, and clear all internal counters and latched operands.
REQ-023 A reset asserted mid-operation SHALL abort scoring with no done pulse; the next start after reset deasserts SHALL begin a fresh scoring.

Verification
REQ-024 The bench SHALL drive secret=(1,2,3,4), guess=(1,2,3,4), pulse start -> busy high for 13 cycles, then done=1, black=4, white=0, win=1.
REQ-025 The bench SHALL drive secret=(1,2,3,4), guess=(4,3,2,1) -> black=0, white=4, win=0.
REQ-026 The bench SHALL drive secret=(1,1,2,2), guess=(1,2,1,5) -> black=1, white=2, win=0; it SHALL also change guess during busy and check that the result is unchanged.
REQ-027 The bench SHALL drive secret=(0,0,0,0), guess=(7,7,7,7) -> black=0, white=0; then hold start high for 30 cycles -> done pulses exactly 14 cycles apart and no extra pulses from start while busy.
REQ-028 The bench SHALL assert reset=0 asynchronously in the 2nd BLACK cycle -> all outputs 0 at once with no done pulse; after release and a new start, the correct result arrives at the normal latency.

Source files
------------

// File: rtl/mmind_scorer_if.sv
// mmind_scorer_if -- operand/result bundle for the Mastermind scorer.
//   start        : request to score the current secret/guess pair
//   secret/guess : four pegs of COLOR_W bits each, {p3,p2,p1,p0}, p0 in LSBs
//   busy         : scoring in progress
//   done         : one-cycle pulse, results below are new
//   black/white  : position+colour matches / colour-only matches (0..4)
//   win          : all four pegs matched
// master = requester side, slave = scorer side.
interface mmind_scorer_if #(
    parameter int COLOR_W = 3
);
    logic                   start;
    logic [4*COLOR_W-1:0]   secret;
    logic [4*COLOR_W-1:0]   guess;
    logic                   busy;
    logic                   done;
    logic [2:0]             black;
    logic [2:0]             white;
    logic                   win;

    modport master (
        output start, secret, guess,
        input  busy, done, black, white, win
    );

    modport slave (
        input  start, secret, guess,
        output busy, done, black, white, win
    );
endinterface

// File: rtl/mmind_scorer.sv
// mmind_scorer -- sequential Mastermind scorer.
// Latches a secret/guess pair on start, counts positional matches one peg
// per cycle (4 cycles), then sums min(secret count, guess count) one colour
// per cycle (2^COLOR_W cycles), and publishes black/white/win with a done
// pulse. Results hold until the next completed scoring or reset.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : mmind_scorer_if.slave (start, secret, guess -> busy, done,
//           black, white, win)
module mmind_scorer #(
    parameter int COLOR_W = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    mmind_scorer_if.slave           bus
);
    typedef enum logic [1:0] {IDLE, BLACK, COLOR, FINISH} state_t;

    localparam logic [COLOR_W-1:0] COLOR_ONE  = {{(COLOR_W-1){1'b0}}, 1'b1};
    localparam logic [COLOR_W-1:0] COLOR_LAST = {COLOR_W{1'b1}};

    state_t               state_reg, state_next;
    logic [4*COLOR_W-1:0] secret_reg, secret_next;
    logic [4*COLOR_W-1:0] guess_reg, guess_next;
    logic [1:0]           idx_reg, idx_next;
    logic [COLOR_W-1:0]   color_reg, color_next;
    logic [2:0]           black_acc_reg, black_acc_next;
    logic [2:0]           total_reg, total_next;
    logic [2:0]           black_reg, black_next;
    logic [2:0]           white_reg, white_next;
    logic                 win_reg, win_next;
    logic                 done_reg, done_next;

    // Per-peg views of the latched operands.
    logic [COLOR_W-1:0] sec_peg [4];
    logic [COLOR_W-1:0] gue_peg [4];
    logic [3:0]         pos_match;
    logic [3:0]         sec_hit;
    logic [3:0]         gue_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_peg
            assign sec_peg[gi]   = secret_reg[gi*COLOR_W +: COLOR_W];
            assign gue_peg[gi]   = guess_reg[gi*COLOR_W +: COLOR_W];
            assign pos_match[gi] = (sec_peg[gi] == gue_peg[gi]);
            assign sec_hit[gi]   = (sec_peg[gi] == color_reg);
            assign gue_hit[gi]   = (gue_peg[gi] == color_reg);
        end
    endgenerate

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    logic [2:0] sec_cnt, gue_cnt, min_cnt;
    assign sec_cnt = popcount4(sec_hit);
    assign gue_cnt = popcount4(gue_hit);
    assign min_cnt = (sec_cnt < gue_cnt) ? sec_cnt : gue_cnt;

    always_comb begin
        state_next     = state_reg;
        secret_next    = secret_reg;
        guess_next     = guess_reg;
        idx_next       = idx_reg;
        color_next     = color_reg;
        black_acc_next = black_acc_reg;
        total_next     = total_reg;
        black_next     = black_reg;
        white_next     = white_reg;
        win_next       = win_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    secret_next    = bus.secret;
                    guess_next     = bus.guess;
                    idx_next       = 2'd0;
                    color_next     = '0;
                    black_acc_next = 3'd0;
                    total_next     = 3'd0;
                    state_next     = BLACK;
                end
            end
            BLACK: begin
                if (pos_match[idx_reg]) begin
                    black_acc_next = black_acc_reg + 3'd1;
                end
                idx_next = idx_reg + 2'd1;
                if (idx_reg == 2'd3) begin
                    color_next = '0;
                    state_next = COLOR;
                end
            end
            COLOR: begin
                total_next = total_reg + min_cnt;
                color_next = color_reg + COLOR_ONE;
                if (color_reg == COLOR_LAST) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                // total counts every colour match including positional ones,
                // so it never falls below black_acc.
                black_next = black_acc_reg;
                white_next = total_reg - black_acc_reg;
                win_next   = (black_acc_reg == 3'd4);
                done_next  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            secret_reg    <= '0;
            guess_reg     <= '0;
            idx_reg       <= 2'd0;
            color_reg     <= '0;
            black_acc_reg <= 3'd0;
            total_reg     <= 3'd0;
            black_reg     <= 3'd0;
            white_reg     <= 3'd0;
            win_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            secret_reg    <= secret_next;
            guess_reg     <= guess_next;
            idx_reg       <= idx_next;
            color_reg     <= color_next;
            black_acc_reg <= black_acc_next;
            total_reg     <= total_next;
            black_reg     <= black_next;
            white_reg     <= white_next;
            win_reg       <= win_next;
            done_reg      <= done_next;
        end
    end

    assign bus.busy  = (state_reg != IDLE);
    assign bus.done  = done_reg;
    assign bus.black = black_reg;
    assign bus.white = white_reg;
    assign bus.win   = win_reg;
endmodule

// File: tb/tb_mmind_scorer.sv
// tb_mmind_scorer -- directed self-checking bench for mmind_scorer
// (COLOR_W = 3). Outputs are sampled on the falling clock edge.
module tb_mmind_scorer;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mmind_scorer_if #(.COLOR_W(3)) bus ();

    mmind_scorer #(.COLOR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s got=%0d", tag, got);
        end
    endtask

    // Pack (p3,p2,p1,p0) into {p3,p2,p1,p0}.
    function automatic logic [11:0] pk(input int p3, input int p2, input int p1, input int p0);
        logic [2:0] a, b, c, d;
        a = p3[2:0]; b = p2[2:0]; c = p1[2:0]; d = p0[2:0];
        return {a, b, c, d};
    endfunction

    // One scoring: start for one cycle, count busy cycles until done,
    // optionally scramble guess while busy, check results and pulse width.
    task automatic score(input string tag, input logic [11:0] s, input logic [11:0] g,
                         input logic chg, input int eb, input int ew, input int ewin);
        int cyc;
        logic seen;
        cyc  = 0;
        seen = 1'b0;
        @(negedge clk);
        bus.secret = s;
        bus.guess  = g;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) cyc++;
            if (chg && i == 3) begin
                bus.guess  = ~g;
                bus.secret = ~s;
            end
            @(negedge clk);
        end
        check({tag, ".done_seen"}, 32'(seen), 32'd1);
        check({tag, ".busy_cycles"}, 32'(cyc), 32'd13);
        check({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
        check({tag, ".black"}, 32'(bus.black), 32'(eb));
        check({tag, ".white"}, 32'(bus.white), 32'(ew));
        check({tag, ".win"}, 32'(bus.win), 32'(ewin));
        @(negedge clk);
        check({tag, ".done_one_cycle"}, 32'(bus.done), 32'd0);
        check({tag, ".black_hold"}, 32'(bus.black), 32'(eb));
    endtask

    initial begin
        int pulses;
        int first_idx;
        int second_idx;
        logic done_seen;
        logic idle_ok;

        bus.start  = 1'b0;
        bus.secret = '0;
        bus.guess  = '0;
        reset      = 1'b0;
        #2;
        check("reset.busy", 32'(bus.busy), 32'd0);
        check("reset.done", 32'(bus.done), 32'd0);
        check("reset.black", 32'(bus.black), 32'd0);
        check("reset.white", 32'(bus.white), 32'd0);
        check("reset.win", 32'(bus.win), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        score("exact", pk(1,2,3,4), pk(1,2,3,4), 1'b0, 4, 0, 1);
        score("perm", pk(1,2,3,4), pk(4,3,2,1), 1'b0, 0, 4, 0);
        score("mixed", pk(1,1,2,2), pk(1,2,1,5), 1'b1, 1, 2, 0);
        score("disjoint", pk(0,0,0,0), pk(7,7,7,7), 1'b0, 0, 0, 0);

        // Continuous start: expect done at negedge index 13 and 27.
        pulses     = 0;
        first_idx  = -1;
        second_idx = -1;
        @(negedge clk);
        bus.secret = pk(3,3,5,5);
        bus.guess  = pk(5,3,3,6);
        bus.start  = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                if (first_idx < 0) first_idx = i;
                else if (second_idx < 0) second_idx = i;
            end
        end
        bus.start = 1'b0;
        check("held.pulses", 32'(pulses), 32'd2);
        check("held.first_idx", 32'(first_idx), 32'd13);
        check("held.period", 32'(second_idx - first_idx), 32'd14);
        check("held.black", 32'(bus.black), 32'd1);
        check("held.white", 32'(bus.white), 32'd2);
        idle_ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy && !bus.done) begin
                idle_ok = 1'b1;
                break;
            end
        end
        check("held.drain_idle", 32'(idle_ok), 32'd1);

        // Leave a nonzero result so the reset clearing is visible.
        score("prewin", pk(6,5,4,3), pk(6,5,4,3), 1'b0, 4, 0, 1);

        // Reset in the 2nd BLACK cycle, between clock edges.
        @(negedge clk);
        bus.secret = pk(1,2,3,4);
        bus.guess  = pk(1,2,3,0);
        bus.start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        check("abort.black", 32'(bus.black), 32'd0);
        check("abort.white", 32'(bus.white), 32'd0);
        check("abort.win", 32'(bus.win), 32'd0);
        done_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done) done_seen = 1'b1;
        end
        reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_seen = 1'b1;
        end
        check("abort.no_done", 32'(done_seen), 32'd0);
        score("after_reset", pk(1,2,3,4), pk(1,2,3,0), 1'b0, 3, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
